add_serial: RTL

- Multi-cycle 32-bit adder with carry-in/carry-out. It is the carry-propagating counterpart of the ripple-borrow subtractor in the SimpleRisc ALU path.
- Each cycle it processes one CHUNK-bit slice of the operands and holds the inter-slice carry in a register. The carry chain is cut into CHUNK-bit segments, which trades latency for a short critical path.
- It sits beside the ALU and serves multi-cycle add and address-increment operations through a start/busy/done handshake.

---
 rtl/add_serial.sv | 94 +++++++++
 1 files changed

// File: rtl/add_serial.sv
// Multi-cycle adder: sums one CHUNK-bit slice per cycle and keeps the inter-slice carry
// in a register, trading latency for a short carry chain. Uses a start/busy/done handshake.
module add_serial #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("CHUNK must divide WIDTH");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic [WIDTH-1:0] a_q, b_q;
   logic             carry;
   logic [CW-1:0]    cnt;
   int               base;
   logic [CHUNK-1:0] sa, sb;
   logic [CHUNK:0]   ssum;
   logic             last, accept, msb_cin;

   // current slice; msb_cin recovers the carry into the slice's top bit
   always_comb begin
      base    = int'(cnt) * CHUNK;
      sa      = a_q[base +: CHUNK];
      sb      = b_q[base +: CHUNK];
      ssum    = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, carry};
      msb_cin = sa[CHUNK-1] ^ sb[CHUNK-1] ^ ssum[CHUNK-1];
   end

   assign last   = (cnt == CW'(N - 1));
   assign accept = start && (state != RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         carry <= c_in;
         cnt   <= '0;
         sum   <= '0;
      end else if (state == RUN) begin
         sum[base +: CHUNK] <= ssum[CHUNK-1:0];
         carry              <= ssum[CHUNK];
         cnt                <= cnt + 1'b1;
         if (last) begin
            c_out    <= ssum[CHUNK];
            overflow <= msb_cin ^ ssum[CHUNK];
         end
      end
   end
endmodule
